// File: rtl/wb_pwm_fader.sv
// wb_pwm_fader: Wishbone PWM LED driver with a prescaled 1-LSB-per-step sunrise/sunset ramp.
// Define WB_PWM_FADER_IRQ_EN to add irq_o and the read/write CTRL[3] interrupt-enable bit.
module wb_pwm_fader #(
  parameter int PWM_W = 8,
  parameter int DIV_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        pwm_o,
`ifdef WB_PWM_FADER_IRQ_EN
  output logic        done_o,
  output logic        irq_o
`else
  output logic        done_o
`endif
);
`ifdef WB_PWM_FADER_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RAMP = 1'b1;
  localparam logic [PWM_W-1:0] PMAX = {{(PWM_W-1){1'b1}}, 1'b0};
  logic             ack_q, ack_d, en_q, en_d, inv_q, inv_d, ie_q, ie_d, done_q, done_d;
  logic [31:0]      dat_q, dat_d, rdata;
  logic [PWM_W-1:0] tgt_q, tgt_d, lvl_q, lvl_d, pcnt_q, pcnt_d, duty_q, duty_d, step_lvl;
  logic [DIV_W-1:0] div_q, div_d, pre_q, pre_d;
  logic [0:0]       state_q, state_d;
  logic             req, wr, wr_ctrl, start, set_done;
  logic [2:0]       a;
  logic             unused_bits;
  assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:DIV_W], wb_sel_i[3:1]};
  always_comb begin
    req      = wb_stb_i & wb_cyc_i & ~ack_q;
    wr       = req & wb_we_i & wb_sel_i[0];
    a        = wb_adr_i[4:2];
    wr_ctrl  = wr && a == 3'd0;
    start    = wr_ctrl & wb_dat_i[2];
    ack_d    = req;
    en_d     = wr_ctrl ? wb_dat_i[0] : en_q;
    inv_d    = wr_ctrl ? wb_dat_i[1] : inv_q;
    ie_d     = wr_ctrl ? wb_dat_i[3] & IRQ_EN : ie_q;
    tgt_d    = (wr && a == 3'd1) ? wb_dat_i[PWM_W-1:0] : tgt_q;
    div_d    = (wr && a == 3'd3) ? wb_dat_i[DIV_W-1:0] : div_q;
    step_lvl = lvl_q < tgt_q ? lvl_q + 1'b1 : lvl_q > tgt_q ? lvl_q - 1'b1 : lvl_q;
    state_d  = state_q;
    lvl_d    = lvl_q;
    pre_d    = pre_q;
    set_done = 1'b0;
    // Steps use the pre-edge TARGET, so a TARGET write only steers the following step.
    if (state_q == IDLE) begin
      if (start && en_d) begin
        if (lvl_q != tgt_q) begin
          state_d = RAMP;
          pre_d   = '0;
        end else set_done = 1'b1;
      end
    end else if (!en_d) state_d = IDLE;
    else if (start) pre_d = '0;
    else if (div_q == '0) begin
      lvl_d    = tgt_q;
      state_d  = IDLE;
      set_done = 1'b1;
    end else if (pre_q == div_q - 1'b1) begin
      pre_d = '0;
      lvl_d = step_lvl;
      if (step_lvl == tgt_q) begin
        state_d  = IDLE;
        set_done = 1'b1;
      end
    end else pre_d = pre_q + 1'b1;
    done_d = set_done | (done_q & ~(wr && a == 3'd4 && wb_dat_i[1]));
    pcnt_d = (!en_q || pcnt_q == PMAX) ? '0 : pcnt_q + 1'b1;
    // Duty is latched only as a new period begins so a LEVEL step never splits a period.
    duty_d = (!en_q || pcnt_d == '0) ? lvl_q : duty_q;
    rdata  = a == 3'd0 ? {28'd0, ie_q, 1'b0, inv_q, en_q}
           : a == 3'd1 ? 32'(tgt_q)
           : a == 3'd2 ? 32'(lvl_q)
           : a == 3'd3 ? 32'(div_q)
           : a == 3'd4 ? {30'd0, done_q, state_q == RAMP}
           : 32'd0;
    dat_d  = (req && !wb_we_i) ? rdata : dat_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      en_q    <= 1'b0;
      inv_q   <= 1'b0;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      tgt_q   <= '0;
      lvl_q   <= '0;
      div_q   <= '0;
      pre_q   <= '0;
      pcnt_q  <= '0;
      duty_q  <= '0;
      state_q <= IDLE;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      en_q    <= en_d;
      inv_q   <= inv_d;
      ie_q    <= ie_d;
      done_q  <= done_d;
      tgt_q   <= tgt_d;
      lvl_q   <= lvl_d;
      div_q   <= div_d;
      pre_q   <= pre_d;
      pcnt_q  <= pcnt_d;
      duty_q  <= duty_d;
      state_q <= state_d;
    end
  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign done_o   = done_q;
  assign pwm_o    = en_q ? ((pcnt_q < duty_q) ^ inv_q) : inv_q;
`ifdef WB_PWM_FADER_IRQ_EN
  assign irq_o    = done_q & ie_q;
`endif
endmodule

// File: tb/tb_wb_pwm_fader.sv
// tb_wb_pwm_fader: directed bus sequences checked cycle-by-cycle against an event-scheduled model.
module tb_wb_pwm_fader;
  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0, wb_ack_o, pwm_o, done_o;
  logic [3:0]  wb_sel_i = '0;
`ifdef WB_PWM_FADER_IRQ_EN
  logic        irq_o;
`endif
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  wb_pwm_fader dut (
    .clk(clk), .rst(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
    .wb_ack_o(wb_ack_o), .pwm_o(pwm_o),
`ifdef WB_PWM_FADER_IRQ_EN
    .irq_o(irq_o),
`endif
    .done_o(done_o)
  );
  // Model: registers as the spec describes them, ramp steps scheduled at absolute edge numbers.
  logic        m_ack, m_en, m_inv, m_ie, m_done, m_busy;
  logic [31:0] m_dat;
  logic [7:0]  m_tgt, m_lvl, m_duty, lvl_old;
  logic [15:0] m_div;
  int          m_n, m_next, m_en_edge;
  logic        req, wr, start, en_new, en_old, set_d;
  logic [2:0]  a;
  function automatic logic [31:0] rdm(input logic [2:0] x);
    return x == 3'd0 ? {28'd0, m_ie, 1'b0, m_inv, m_en} : x == 3'd1 ? {24'd0, m_tgt}
         : x == 3'd2 ? {24'd0, m_lvl} : x == 3'd3 ? {16'd0, m_div}
         : x == 3'd4 ? {30'd0, m_done, m_busy} : 32'd0;
  endfunction
  always @(posedge clk or negedge rst)
    if (!rst) begin
      {m_ack, m_en, m_inv, m_ie, m_done, m_busy} = '0;
      m_dat = '0; m_tgt = '0; m_lvl = '0; m_duty = '0; m_div = '0;
      m_n = 0; m_next = 0; m_en_edge = 0;
    end else begin
      m_n++;
      req = wb_stb_i & wb_cyc_i & ~m_ack;
      wr = req & wb_we_i & wb_sel_i[0];
      a = wb_adr_i[4:2];
      en_old = m_en;
      lvl_old = m_lvl;
      en_new = (wr && a == 0) ? wb_dat_i[0] : m_en;
      start = wr && a == 0 && wb_dat_i[2];
      set_d = 1'b0;
      if (req && !wb_we_i) m_dat = rdm(a);
      m_ack = req;
      if (m_busy) begin
        if (!en_new) m_busy = 1'b0;
        else if (start) m_next = m_n + (m_div == 0 ? 1 : int'(m_div));
        else if (m_n == m_next) begin
          if (m_div == 0) m_lvl = m_tgt;
          else if (m_lvl < m_tgt) m_lvl++;
          else if (m_lvl > m_tgt) m_lvl--;
          m_next = m_n + int'(m_div);
          if (m_lvl == m_tgt) begin m_busy = 1'b0; set_d = 1'b1; end
        end
      end else if (start && en_new) begin
        if (m_lvl != m_tgt) begin m_busy = 1'b1; m_next = m_n + (m_div == 0 ? 1 : int'(m_div)); end
        else set_d = 1'b1;
      end
      m_done = set_d | (m_done & ~(wr && a == 4 && wb_dat_i[1]));
      if (wr && a == 0) begin
        m_inv = wb_dat_i[1];
`ifdef WB_PWM_FADER_IRQ_EN
        m_ie = wb_dat_i[3];
`endif
      end
      if (wr && a == 1) m_tgt = wb_dat_i[7:0];
      if (wr && a == 3) m_div = wb_dat_i[15:0];
      m_en = en_new;
      if (!en_old || (m_n - m_en_edge) % 255 == 0) m_duty = lvl_old;
      if (!en_old && en_new) m_en_edge = m_n;
    end
  function automatic logic m_pwm();
    return m_en ? ((((m_n - m_en_edge) % 255) < int'(m_duty)) ^ m_inv) : m_inv;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic bus(input logic we, input logic [7:0] off, input logic [31:0] d,
                     input logic [3:0] sel, output logic [31:0] rd);
    @(negedge clk);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we; wb_adr_i = {24'd0, off}; wb_dat_i = d; wb_sel_i = sel;
    @(posedge clk); #1;
    chk("ack_latency", wb_ack_o, 1);
    rd = wb_dat_o;
    @(negedge clk);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask
  task automatic wr_reg(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, off, d, 4'hF, r);
  endtask
  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, off, 32'd0, 4'hF, r);
    chk(name, r, exp);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic count_hi(output int hi);
    hi = 0;
    repeat (255) begin @(negedge clk); hi += int'(pwm_o); end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int hi;
    logic [31:0] r;
    logic [7:0] lv_exp [8];
    fork
      forever @(negedge clk) if (rst) begin
        chk("mon_ack", wb_ack_o, m_ack);
        chk("mon_dat", wb_dat_o, m_dat);
        chk("mon_pwm", pwm_o, m_pwm());
        chk("mon_done", done_o, m_done);
`ifdef WB_PWM_FADER_IRQ_EN
        chk("mon_irq", irq_o, m_done & m_ie);
`endif
      end
    join_none
    lv_exp = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm_o, 0); chk("rst_done", done_o, 0);
    chk("rst_ack", wb_ack_o, 0); chk("rst_dat", wb_dat_o, 0);
    #3 rst = 1'b1;
    for (int i = 0; i < 8; i++) rd_chk("rst_read", 8'(i * 4), 0);
    // Slow ramp 0 -> 3 with 4 clocks per step; LEVEL read every second cycle.
    wr_reg(8'h0C, 4); wr_reg(8'h04, 3); wr_reg(8'h00, 1); wr_reg(8'h00, 5);
    for (int i = 0; i < 8; i++) rd_chk("ramp_level", 8'h08, {24'd0, lv_exp[i]});
    rd_chk("ramp_status_done", 8'h10, 2);
    wr_reg(8'h10, 2); rd_chk("w1c_done", 8'h10, 0);
    // Instant jump with STEP_DIV=0.
    wr_reg(8'h0C, 0); wr_reg(8'h04, 8'h40); wr_reg(8'h00, 5);
    rd_chk("jump_level", 8'h08, 8'h40);
    chk("jump_done", done_o, 1);
    idle(300); count_hi(hi); chk("duty_64", hi, 64);
    // Abort a ramp by clearing EN at LEVEL=5.
    wr_reg(8'h04, 0); wr_reg(8'h00, 5); idle(2); wr_reg(8'h10, 2);
    wr_reg(8'h0C, 4); wr_reg(8'h04, 8'h10); wr_reg(8'h00, 5);
    rd_chk("busy_mid", 8'h10, 1);
    idle(19); wr_reg(8'h00, 0);
    rd_chk("abort_level", 8'h08, 5); rd_chk("abort_status", 8'h10, 0);
    chk("abort_pwm", pwm_o, 0);
    wr_reg(8'h00, 2); chk("off_inv_pwm", pwm_o, 1); wr_reg(8'h00, 0);
    // Full scale, inversion, then ramp down to the floor.
    wr_reg(8'h0C, 0); wr_reg(8'h04, 8'hFF); wr_reg(8'h00, 1); wr_reg(8'h00, 5);
    idle(300); count_hi(hi); chk("duty_full", hi, 255);
    wr_reg(8'h00, 3); idle(2); count_hi(hi); chk("duty_full_inv", hi, 0);
    wr_reg(8'h0C, 1); wr_reg(8'h04, 0); wr_reg(8'h00, 7);
    idle(300); rd_chk("floor_level", 8'h08, 0); rd_chk("floor_status", 8'h10, 2);
    wr_reg(8'h10, 2); wr_reg(8'h00, 7);
    rd_chk("equal_start_done", 8'h10, 2); rd_chk("floor_hold", 8'h08, 0);
    // Retarget mid-ramp: 0 -> toward 10, redirected to 1.
    wr_reg(8'h00, 1); wr_reg(8'h10, 2); wr_reg(8'h0C, 3); wr_reg(8'h04, 10); wr_reg(8'h00, 5);
    idle(10); wr_reg(8'h04, 1); idle(20);
    rd_chk("retarget_level", 8'h08, 1); rd_chk("retarget_status", 8'h10, 2);
    // START mid-ramp keeps ramping without setting DONE.
    wr_reg(8'h10, 2); wr_reg(8'h0C, 6); wr_reg(8'h04, 3); wr_reg(8'h00, 5);
    idle(3); wr_reg(8'h00, 5); rd_chk("restart_status", 8'h10, 1);
    idle(30); rd_chk("restart_level", 8'h08, 3);
    // Ignored accesses.
    wr_reg(8'h14, 32'hFFFF_FFFF); rd_chk("hole_read", 8'h14, 0);
    bus(1'b1, 8'h04, 32'h55, 4'hE, r); rd_chk("sel0_ignored", 8'h04, 3);
    rd_chk("ctrl_read", 8'h00, 1);
    // Asynchronous reset in the middle of a ramp.
    wr_reg(8'h0C, 4); wr_reg(8'h04, 10); wr_reg(8'h00, 5); idle(6);
    #3 rst = 1'b0;
    #1 chk("arst_pwm", pwm_o, 0); chk("arst_done", done_o, 0); chk("arst_ack", wb_ack_o, 0);
    @(negedge clk); #3 rst = 1'b1;
    rd_chk("arst_level", 8'h08, 0); rd_chk("arst_status", 8'h10, 0); rd_chk("arst_ctrl", 8'h00, 0);
`ifdef WB_PWM_FADER_IRQ_EN
    wr_reg(8'h0C, 2); wr_reg(8'h04, 2); wr_reg(8'h00, 9); wr_reg(8'h00, 13);
    idle(10); chk("irq_set", irq_o, 1); chk("irq_done", done_o, 1);
    rd_chk("ie_read", 8'h00, 9);
    wr_reg(8'h10, 2); chk("irq_clr", irq_o, 0);
    wr_reg(8'h0C, 4); wr_reg(8'h04, 3); wr_reg(8'h00, 13);
    idle(2); wr_reg(8'h10, 2);
    chk("w1c_race_done", done_o, 1); chk("w1c_race_irq", irq_o, 1);
`endif
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
